// File: rtl/walk_pkg.sv
// Shared types and helpers for the multi-channel walk request arbiter.
// Holds the arbiter FSM encoding, the channel-index width helper and the round-robin picker.
package walk_pkg;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} walkState_e;

    localparam int unsigned MAX_CH   = 32;
    localparam int unsigned MAX_CH_W = 5;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } rrPick_t;

    function automatic int unsigned chWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask at or after start, wrapping within numCh channels.
    function automatic rrPick_t rrPick(input logic [MAX_CH-1:0] mask,
                                       input int unsigned numCh,
                                       input int unsigned start);
        rrPick_t     r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < numCh) begin
                j = start + k;
                if (j >= numCh) j = j - numCh;
                if (!r.found && mask[j[MAX_CH_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_CH_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/walk_debounce.sv
// Per-button synchroniser and debouncer: one registered accept pulse per qualified press.
// Sync flops and hold flag come out of reset set, so a button held through reset must be released first.
module walk_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic sys_reset_n,
    input  logic btn_async,
    output logic accept_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             metaQ, syncedQ, heldQ, acceptQ;
    logic [CNT_W-1:0] countQ;

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            metaQ   <= 1'b1;
            syncedQ <= 1'b1;
            heldQ   <= 1'b1;
            acceptQ <= 1'b0;
            countQ  <= '0;
        end else begin
            metaQ   <= btn_async;
            syncedQ <= metaQ;
            acceptQ <= 1'b0;
            if (!syncedQ) begin
                countQ <= '0;
                heldQ  <= 1'b0;
            end else if (!heldQ) begin
                if (countQ == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    acceptQ <= 1'b1;
                    heldQ   <= 1'b1;
                end
                countQ <= countQ + 1'b1;
            end
        end
    end

    assign accept_pulse = acceptQ;

endmodule

// File: rtl/walk_request_arbiter.sv
// Debounced multi-crosswalk request latch with ageing and urgent-first round-robin presentation
// to the traffic controller over a valid/ack handshake.
module walk_request_arbiter
    import walk_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WAIT_W          = 16,
    parameter int unsigned MAX_WAIT        = 1000,
    localparam int unsigned CH_W           = chWidth(NUM_CH)
) (
    input  logic              clk,
    input  logic              sys_reset_n,
    input  logic [NUM_CH-1:0] walk_btn,
    input  logic [NUM_CH-1:0] walk_clear,
    input  logic              req_ack,
    output logic [NUM_CH-1:0] walk_status,
    output logic              req_valid,
    output logic [CH_W-1:0]   req_ch,
    output logic              req_urgent,
    output logic [WAIT_W-1:0] req_age
);

    logic [NUM_CH-1:0] accept, clearVec, urgent, candidates, pool, statusQ, statusD;
    logic [WAIT_W-1:0] ageQ [NUM_CH];
    walkState_e        stateQ, stateD;
    logic              reqValidQ, reqValidD, reqUrgentQ, reqUrgentD;
    logic [CH_W-1:0]   reqChQ, reqChD, lastServedQ, lastServedD, startIdx;
    rrPick_t           pick;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_debounce
        walk_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .sys_reset_n (sys_reset_n),
            .btn_async   (walk_btn[g]),
            .accept_pulse(accept[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            clearVec[i] = walk_clear[i] | (req_ack & reqValidQ & (reqChQ == CH_W'(i)));
            urgent[i]   = statusQ[i] & (ageQ[i] >= WAIT_W'(MAX_WAIT));
        end
    end

    // Clear wins over a same-cycle accept.
    assign statusD    = (statusQ | accept) & ~clearVec;
    assign candidates = statusQ & ~walk_clear;
    assign pool       = (|(candidates & urgent)) ? (candidates & urgent) : candidates;
    assign startIdx   = (lastServedQ == CH_W'(NUM_CH - 1)) ? '0 : lastServedQ + 1'b1;
    assign pick       = rrPick(MAX_CH'(pool), NUM_CH, 32'(startIdx));

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            statusQ <= '0;
            for (int i = 0; i < NUM_CH; i++) ageQ[i] <= '0;
        end else begin
            statusQ <= statusD;
            for (int i = 0; i < NUM_CH; i++) begin
                if (clearVec[i] || !statusQ[i]) begin
                    ageQ[i] <= '0;
                end else if (ageQ[i] != '1) begin
                    ageQ[i] <= ageQ[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateD      = stateQ;
        reqValidD   = reqValidQ;
        reqChD      = reqChQ;
        reqUrgentD  = reqUrgentQ;
        lastServedD = lastServedQ;
        unique case (stateQ)
            IDLE: begin
                if (pick.found) begin
                    reqChD     = CH_W'(pick.idx);
                    reqUrgentD = urgent[reqChD];
                    reqValidD  = 1'b1;
                    stateD     = PRESENT;
                end
            end
            PRESENT: begin
                if (req_ack) begin
                    lastServedD = reqChQ;
                    reqValidD   = 1'b0;
                    stateD      = GAP;
                end else if (walk_clear[reqChQ]) begin
                    reqValidD = 1'b0;
                    stateD    = GAP;
                end
            end
            GAP:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            stateQ      <= IDLE;
            reqValidQ   <= 1'b0;
            reqChQ      <= '0;
            reqUrgentQ  <= 1'b0;
            lastServedQ <= CH_W'(NUM_CH - 1);
        end else begin
            stateQ      <= stateD;
            reqValidQ   <= reqValidD;
            reqChQ      <= reqChD;
            reqUrgentQ  <= reqUrgentD;
            lastServedQ <= lastServedD;
        end
    end

    assign walk_status = statusQ;
    assign req_valid   = reqValidQ;
    assign req_ch      = reqChQ;
    assign req_urgent  = reqUrgentQ;
    assign req_age     = ageQ[reqChQ];

endmodule

// File: tb/tb_walk_request_arbiter.sv
// Scenario tasks plus a per-cycle comparison against a behavioural model of the walk arbiter.
module tb_walk_request_arbiter;

    localparam int N = 4, D = 16, WW = 16, MW = 50, AGE_MAX = 65535;

    logic        clk = 1'b0, sys_reset_n = 1'b0, req_ack = 1'b0;
    logic [3:0]  walk_btn = '0, walk_clear = '0;
    logic [3:0]  walk_status;
    logic        req_valid, req_urgent;
    logic [1:0]  req_ch;
    logic [15:0] req_age;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    walk_request_arbiter #(
        .NUM_CH(N), .DEBOUNCE_CYCLES(D), .WAIT_W(WW), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .walk_btn(walk_btn), .walk_clear(walk_clear),
        .req_ack(req_ack), .walk_status(walk_status), .req_valid(req_valid), .req_ch(req_ch),
        .req_urgent(req_urgent), .req_age(req_age)
    );

    // Model: a press counts once the raw level has been high for D sampled edges, and the
    // pending flag rises three edges after that (two sync stages plus the accept register).
    bit [3:0] mPend, mHeld;
    bit [2:0] mPipe [4];
    int       mAge [4], mRun [4];
    bit       mValid, mUrg, mGap;
    int       mCh, mLast;

    always @(posedge clk or negedge sys_reset_n) begin : ref_model
        bit [3:0] acc, clr, cand, pool;
        bit       hit, found;
        int       run, c;
        if (!sys_reset_n) begin
            mPend <= '0; mHeld <= '1; mValid <= 0; mUrg <= 0; mGap <= 0; mCh <= 0; mLast <= N - 1;
            for (int i = 0; i < N; i++) begin
                mAge[i] <= 0; mRun[i] <= 0; mPipe[i] <= '0;
            end
        end else begin
            clr = walk_clear;
            if (req_ack && mValid) clr[mCh] = 1'b1;
            for (int i = 0; i < N; i++) begin
                acc[i] = mPipe[i][2];
                hit = 0;
                run = mRun[i];
                if (!walk_btn[i]) begin
                    run = 0; mHeld[i] <= 0;
                end else if (!mHeld[i]) begin
                    run++;
                    if (run == D) begin hit = 1; mHeld[i] <= 1; end
                end
                mRun[i]  <= run;
                mPipe[i] <= {mPipe[i][1:0], hit};
                mPend[i] <= clr[i] ? 1'b0 : (mPend[i] | acc[i]);
                mAge[i]  <= (clr[i] || !mPend[i]) ? 0 : (mAge[i] < AGE_MAX ? mAge[i] + 1 : mAge[i]);
            end
            if (mValid) begin
                if (req_ack) begin
                    mLast <= mCh; mValid <= 0; mGap <= 1;
                end else if (walk_clear[mCh]) begin
                    mValid <= 0; mGap <= 1;
                end
            end else if (mGap) begin
                mGap <= 0;
            end else begin
                cand = mPend & ~walk_clear;
                pool = '0;
                for (int i = 0; i < N; i++) if (cand[i] && mAge[i] >= MW) pool[i] = 1;
                if (pool == 0) pool = cand;
                found = 0;
                for (int off = 1; off <= N; off++) begin
                    c = (mLast + off) % N;
                    if (!found && pool[c]) begin
                        found = 1; mValid <= 1; mCh <= c; mUrg <= (mAge[c] >= MW);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (sys_reset_n) begin
            checks++;
            if (walk_status !== mPend || req_valid !== mValid || req_ch !== 2'(mCh) ||
                req_urgent !== mUrg || req_age !== 16'(mAge[mCh])) begin
                errors++;
                $display("FAIL model t=%0t status=%b/%b valid=%b/%b ch=%0d/%0d urg=%b/%b age=%0d/%0d",
                         $time, walk_status, mPend, req_valid, mValid, req_ch, mCh,
                         req_urgent, mUrg, req_age, mAge[mCh]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        sys_reset_n = 0; walk_btn = '0; walk_clear = '0; req_ack = 0;
        tick(2);
        sys_reset_n = 1;
        tick(3);
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!req_valid && n < limit) begin tick(); n++; end
        checks++;
        if (!req_valid) begin errors++; $display("FAIL %s timeout valid=%b required 1", name, req_valid); end
    endtask

    task automatic test_reset();
        sys_reset_n = 0;
        tick(2);
        checks++;
        if ({walk_status, req_valid, req_ch, req_urgent, req_age} !== '0) begin
            errors++;
            $display("FAIL reset status=%b valid=%b ch=%0d urg=%b age=%0d required all 0",
                     walk_status, req_valid, req_ch, req_urgent, req_age);
        end
        sys_reset_n = 1;
        tick(3);
    endtask

    task automatic test_single_press();
        walk_btn[2] = 1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 18) begin
                checks++;
                if (walk_status !== 4'b0000) begin errors++; $display("FAIL press_early status=%b required 0000", walk_status); end
            end
            if (n == 19) begin
                checks++;
                if (walk_status !== 4'b0100 || req_valid !== 0) begin
                    errors++; $display("FAIL press_latch status=%b valid=%b required 0100 0", walk_status, req_valid);
                end
            end
            if (n == 20) begin
                checks++;
                if (req_valid !== 1 || req_ch !== 2'd2 || req_urgent !== 0) begin
                    errors++; $display("FAIL press_present valid=%b ch=%0d urg=%b required 1 2 0", req_valid, req_ch, req_urgent);
                end
            end
        end
        walk_btn[2] = 0;
        req_ack = 1;
        tick();
        req_ack = 0;
        checks++;
        if (req_valid !== 0 || walk_status !== 4'b0000) begin
            errors++; $display("FAIL press_ack valid=%b status=%b required 0 0000", req_valid, walk_status);
        end
        tick(3);
    endtask

    task automatic test_glitch();
        int ch;
        walk_btn[1] = 1; tick(10); walk_btn[1] = 0;
        for (int t = 0; t < 6; t++) begin
            ch = $urandom_range(0, 3);
            for (int p = 0; p < 3; p++) begin
                walk_btn[ch] = 1; tick(3);
                walk_btn[ch] = 0; tick($urandom_range(1, 3));
            end
        end
        for (int n = 0; n < 25; n++) begin
            tick();
            checks++;
            if (walk_status !== 4'b0000 || req_valid !== 0) begin
                errors++; $display("FAIL glitch status=%b valid=%b required 0000 0", walk_status, req_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int expOrder[4] = '{0, 1, 3, 0};
        int lowRun = 0, minLow = 99, waitN = 0, pressTicks = 0;
        bit seen = 0, pressed0 = 0;
        do_reset();
        walk_btn = 4'b1011; tick(20); walk_btn = '0;
        for (int cyc = 0; cyc < 400 && order.size() < 4; cyc++) begin
            if (req_valid) begin
                if (!seen) begin
                    if (order.size() > 0 && lowRun < minLow) minLow = lowRun;
                    order.push_back(int'(req_ch)); seen = 1; waitN = $urandom_range(0, 2);
                end
                if (waitN == 0) req_ack = 1; else waitN--;
            end else begin
                req_ack = 0; seen = 0; lowRun++;
                if (order.size() == 2 && !pressed0) begin
                    pressed0 = 1; walk_btn[0] = 1; pressTicks = 20;
                end
            end
            if (req_valid) lowRun = 0;
            if (pressTicks > 0) begin pressTicks--; if (pressTicks == 0) walk_btn[0] = 0; end
            tick();
        end
        req_ack = 0; walk_btn = '0;
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL rr_count served=%0d required 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != expOrder[i]) begin
                    errors++; $display("FAIL rr_order slot %0d ch=%0d required %0d", i, order[i], expOrder[i]);
                end
            end
        end
        checks++;
        if (minLow < 1) begin errors++; $display("FAIL rr_gap low_cycles=%0d required >=1", minLow); end
        tick(3);
    endtask

    task automatic test_urgent();
        do_reset();
        walk_btn[0] = 1; tick(20); walk_btn[0] = 0;
        for (int t = 0; t < 86; t++) begin
            if (t == 0) walk_btn[1] = 1;
            if (t == 20) walk_btn[1] = 0;
            if (t == 30) walk_btn[3] = 1;
            if (t == 50) walk_btn[3] = 0;
            tick();
        end
        checks++;
        if (req_valid !== 1 || req_ch !== 2'd0 || walk_status !== 4'b1011) begin
            errors++; $display("FAIL urg_hold valid=%b ch=%0d status=%b required 1 0 1011", req_valid, req_ch, walk_status);
        end
        walk_clear[0] = 1; tick(); walk_clear[0] = 0;
        wait_valid("urg_wait", 10);
        checks++;
        if (req_ch !== 2'd1 || req_urgent !== 1 || req_age < 16'(MW)) begin
            errors++; $display("FAIL urg_present ch=%0d urg=%b age=%0d required 1 1 >=%0d", req_ch, req_urgent, req_age, MW);
        end
        req_ack = 1; tick(); req_ack = 0;
        wait_valid("urg_next", 10);
        checks++;
        if (req_ch !== 2'd3) begin errors++; $display("FAIL urg_after ch=%0d required 3", req_ch); end
        req_ack = 1; tick(); req_ack = 0; tick(3);
    endtask

    task automatic test_clear_collision();
        do_reset();
        walk_btn[0] = 1; tick(20); walk_btn[0] = 0;
        walk_btn[2] = 1; tick(20); walk_btn[2] = 0; tick(3);
        checks++;
        if (req_valid !== 1 || req_ch !== 2'd0 || walk_status !== 4'b0101) begin
            errors++; $display("FAIL coll_setup valid=%b ch=%0d status=%b required 1 0 0101", req_valid, req_ch, walk_status);
        end
        walk_btn[2] = 1; tick(15);
        req_ack = 1; tick(); req_ack = 0; tick(2);
        checks++;
        if (req_valid !== 1 || req_ch !== 2'd2) begin
            errors++; $display("FAIL coll_present valid=%b ch=%0d required 1 2", req_valid, req_ch);
        end
        walk_clear[2] = 1; tick(); walk_clear[2] = 0; walk_btn[2] = 0;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (req_valid !== 0 || walk_status !== 4'b0000) begin
                errors++; $display("FAIL coll_drop valid=%b status=%b required 0 0000", req_valid, walk_status);
            end
            tick();
        end
        walk_btn = 4'b1010; tick(20); walk_btn = '0;
        wait_valid("coll_rr", 5);
        checks++;
        if (req_ch !== 2'd1) begin errors++; $display("FAIL coll_last ch=%0d required 1", req_ch); end
    endtask

    task automatic test_reset_mid_present();
        do_reset();
        walk_btn[1] = 1; tick(20);
        checks++;
        if (req_valid !== 1 || req_ch !== 2'd1) begin
            errors++; $display("FAIL rst_setup valid=%b ch=%0d required 1 1", req_valid, req_ch);
        end
        #3 sys_reset_n = 0;
        #1;
        checks++;
        if ({walk_status, req_valid, req_ch, req_urgent, req_age} !== '0) begin
            errors++; $display("FAIL rst_async status=%b valid=%b ch=%0d urg=%b age=%0d required all 0",
                               walk_status, req_valid, req_ch, req_urgent, req_age);
        end
        tick(2);
        sys_reset_n = 1;
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (walk_status !== 4'b0000 || req_valid !== 0) begin
                errors++; $display("FAIL rst_held status=%b valid=%b required 0000 0", walk_status, req_valid);
            end
        end
        walk_btn[1] = 0; tick(3);
        walk_btn[1] = 1; tick(19);
        checks++;
        if (walk_status !== 4'b0010) begin errors++; $display("FAIL rst_repress status=%b required 0010", walk_status); end
        walk_btn[1] = 0; tick(3);
    endtask

    task automatic test_random();
        int dur[4];
        do_reset();
        for (int i = 0; i < N; i++) dur[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    walk_btn[i] = ($urandom_range(0, 2) == 0);
                    dur[i] = $urandom_range(1, 30);
                end else dur[i]--;
                walk_clear[i] = ($urandom_range(0, 63) == 0);
            end
            req_ack = req_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            tick();
            if (req_valid) begin
                checks++;
                if (walk_status[req_ch] !== 1'b1) begin
                    errors++; $display("FAIL rand_pending ch=%0d status=%b required bit set", req_ch, walk_status);
                end
            end
        end
        walk_btn = '0; walk_clear = '0; req_ack = 0; tick(5);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_round_robin();
        test_urgent();
        test_clear_collision();
        test_reset_mid_present();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
